// File: rtl/arb_req_queue.sv
// arb_req_queue: four per-requester command FIFOs feeding a 4-way round-robin
// arbiter. REQ reflects FIFO occupancy; a one-hot GNT pops the granted FIFO
// head onto a single registered output tagged with its source index.
module arb_req_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            in_ready,
  output logic [3:0]            REQ,
  input  logic [3:0]            GNT,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_src,
  output logic                  err_gnt,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem    [4][DEPTH];
  logic [CNT_W-1:0]  count  [4];
  logic [PTR_W-1:0]  wr_ptr [4];
  logic [PTR_W-1:0]  rd_ptr [4];

  logic [3:0] push;
  logic [3:0] drop;
  logic [3:0] pop;
  logic       multi;
  logic [1:0] pop_idx;
  logic [2:0] n_drop;
  logic [8:0] drop_sum;

  // Per-FIFO status, push/pop qualification and saturating drop accounting
  always_comb begin
    in_ready = '0;
    REQ      = '0;
    push     = '0;
    drop     = '0;
    pop      = '0;
    pop_idx  = '0;
    n_drop   = '0;
    multi    = (GNT & (GNT - 4'd1)) != 4'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      in_ready[i] = count[i] != CNT_W'(DEPTH);
      REQ[i]      = count[i] != '0;
      push[i]     = in_valid[i] & in_ready[i];
      drop[i]     = in_valid[i] & ~in_ready[i];
      // A grant to an empty FIFO is normal arbiter lag and simply pops nothing
      pop[i]      = GNT[i] & ~multi & REQ[i];
      if (GNT[i]) pop_idx = 2'(i);
      n_drop      = n_drop + 3'(drop[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 9'(n_drop);
  end

  // FIFO storage; not cleared by reset, and writes are blocked while in reset
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (rst && push[i]) mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // Pointer and occupancy update; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rst) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Registered output word, sticky grant error and saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      err_gnt   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      out_valid <= |pop;
      if (|pop) begin
        out_data <= mem[pop_idx][rd_ptr[pop_idx]];
        out_src  <= pop_idx;
      end
      if (multi) err_gnt <= 1'b1;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_arb_req_queue.sv
// Self-checking bench for arb_req_queue: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_arb_req_queue;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_ready;
  logic [3:0]    REQ;
  logic [3:0]    GNT;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          err_gnt;
  logic [7:0]    drop_cnt;

  arb_req_queue #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .REQ(REQ), .GNT(GNT), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .err_gnt(err_gnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: contents of each FIFO and expected registered outputs
  logic [DW-1:0] q [4][$];
  logic          exp_ov;
  logic [DW-1:0] exp_od;
  logic [1:0]    exp_os;
  logic          exp_err;
  int            exp_drop;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all();
    logic [3:0] e_req;
    logic [3:0] e_rdy;
    for (int i = 0; i < 4; i++) begin
      e_req[i] = q[i].size() != 0;
      e_rdy[i] = q[i].size() < DP;
    end
    check("REQ", 32'(REQ), 32'(e_req));
    check("in_ready", 32'(in_ready), 32'(e_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check("out_data", 32'(out_data), 32'(exp_od));
      check("out_src", 32'(out_src), 32'(exp_os));
    end
    check("err_gnt", 32'(err_gnt), 32'(exp_err));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge
  task automatic cycle(input logic r, input logic [3:0] v, input logic [4*DW-1:0] d,
                       input logic [3:0] g);
    int         nb;
    int         pi;
    logic [3:0] had_room;
    rst = r; in_valid = v; in_data = d; GNT = g;
    if (!r) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      exp_ov = 1'b0; exp_od = '0; exp_os = '0; exp_err = 1'b0; exp_drop = 0;
    end else begin
      nb = 0; pi = -1;
      for (int i = 0; i < 4; i++) begin
        if (g[i]) nb++;
        had_room[i] = q[i].size() < DP;
      end
      if (nb > 1) exp_err = 1'b1;
      else if (nb == 1)
        for (int i = 0; i < 4; i++) if (g[i] && q[i].size() > 0) pi = i;
      exp_ov = 1'b0;
      if (pi >= 0) begin
        exp_od = q[pi].pop_front();
        exp_ov = 1'b1;
        exp_os = 2'(pi);
      end
      for (int i = 0; i < 4; i++) begin
        if (v[i]) begin
          if (had_room[i]) q[i].push_back(d[i*DW +: DW]);
          else if (exp_drop < 255) exp_drop++;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  logic [3:0]      rv;
  logic [3:0]      rg;
  logic [4*DW-1:0] rd;
  logic            rr;

  initial begin
    rst = 1'b0; in_valid = '0; in_data = '0; GNT = '0;
    @(negedge clk);

    // Reset then idle
    cycle(1'b0, 4'b0000, '0, 4'b0000);
    cycle(1'b0, 4'b0000, '0, 4'b0000);
    cycle(1'b1, 4'b0000, '0, 4'b0000);

    // Single push/pop on requester 1
    cycle(1'b1, 4'b0010, {8'h00, 8'h00, 8'hA5, 8'h00}, 4'b0000);
    cycle(1'b1, 4'b0000, '0, 4'b0010);
    cycle(1'b1, 4'b0000, '0, 4'b0000);

    // Fill and overflow requester 3, then drain with one over-grant
    for (int k = 1; k <= 5; k++) cycle(1'b1, 4'b1000, {4{8'(k)}}, 4'b0000);
    for (int k = 0; k < 5; k++) cycle(1'b1, 4'b0000, '0, 4'b1000);

    // Rotating grants across all four requesters
    cycle(1'b1, 4'b1111, {8'h40, 8'h30, 8'h20, 8'h10}, 4'b0000);
    cycle(1'b1, 4'b0000, '0, 4'b0001);
    cycle(1'b1, 4'b0000, '0, 4'b0010);
    cycle(1'b1, 4'b0000, '0, 4'b0100);
    cycle(1'b1, 4'b0000, '0, 4'b1000);
    cycle(1'b1, 4'b0000, '0, 4'b0000);

    // Pointer wrap with concurrent push/pop on requester 2
    cycle(1'b1, 4'b0100, {4{8'h60}}, 4'b0000);
    for (int k = 1; k < 10; k++) cycle(1'b1, 4'b0100, {4{8'(8'h60 + k)}}, 4'b0100);
    cycle(1'b1, 4'b0000, '0, 4'b0100);
    cycle(1'b1, 4'b0000, '0, 4'b0000);

    // Illegal multi-hot grant, then reset during a push
    cycle(1'b1, 4'b0011, {8'h00, 8'h00, 8'h22, 8'h11}, 4'b0000);
    cycle(1'b1, 4'b0000, '0, 4'b0011);
    cycle(1'b1, 4'b0000, '0, 4'b0000);
    cycle(1'b0, 4'b0001, {4{8'h77}}, 4'b0000);
    cycle(1'b1, 4'b0000, '0, 4'b0001);

    // Drop counter saturation: fill everything then keep pushing
    for (int k = 0; k < 4; k++) cycle(1'b1, 4'b1111, {4{8'(k)}}, 4'b0000);
    for (int k = 0; k < 70; k++) cycle(1'b1, 4'b1111, {4{8'hEE}}, 4'b0000);
    cycle(1'b0, 4'b0000, '0, 4'b0000);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rr = ($urandom_range(0, 299) != 0);
      rv = 4'($urandom);
      rd = 32'($urandom);
      case ($urandom_range(0, 19))
        0, 1, 2:  rg = 4'b0000;
        3:        rg = 4'($urandom);
        default:  rg = 4'b0001 << $urandom_range(0, 3);
      endcase
      cycle(rr, rv, rd, rg);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
- Upstream stage of the 4-way round-robin arbiter.
- Holds four per-requester command FIFOs and drives the arbiter's REQ vector: a requester's bit is high while its FIFO is non-empty.
- Consumes the arbiter's one-hot GNT and pops the granted FIFO's head onto a single registered output with source index.
- Decouples bursty requesters from the arbitration cadence.

Parameters:
- DATA_W, 8, width of one command word.
- DEPTH, 4, entries per requester FIFO; power of 2, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of each occupancy counter (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising clk; rst=0 resets.
- in_valid  input  4  per-requester push strobe; bit i targets FIFO i.
- in_data  input  4*DATA_W  packed push data; FIFO i uses bits [i*DATA_W +: DATA_W].
- in_ready  output  4  FIFO i not full; combinational from count_i != DEPTH.
- REQ  output  4  to arbiter; REQ[i] = (count_i != 0); combinational from registered counts.
- GNT  input  4  from arbiter; one-hot or zero expected.
- out_valid  output  1  registered; one popped word presented this cycle.
- out_data  output  DATA_W  registered popped word.
- out_src  output  2  registered index of the FIFO that was popped.
- err_gnt  output  1  sticky flag; set on any multi-hot GNT sample.
- drop_cnt  output  8  saturating count of push attempts refused while full.

Behaviour:
- Reset (rst=0 at rising clk):
  - All counts, rd/wr pointers, out_valid, out_data, out_src, err_gnt and drop_cnt are cleared.
  - Hence REQ=0 and in_ready=4'b1111 in the cycle after reset.
  - FIFO storage is not cleared.
  - Reset overrides any same-cycle push or pop, including reset asserted mid-burst; all queued data is discarded.
- Push:
  - FIFO i accepts in_data slice when in_valid[i] && in_ready[i].
  - It writes at wr_ptr_i, then increments wr_ptr_i (wraps modulo DEPTH) and increments count_i.
  - in_valid[i] while full: no write; drop_cnt increments, saturating at 255.
  - Multiple drops in one cycle add the number of refused bits, still saturating.
- Pop:
  - Legal pop of FIFO i when GNT == (4'b0001 << i) and count_i != 0.
  - Next cycle: out_valid=1, out_data = mem_i[rd_ptr_i] as sampled at the grant edge, out_src=i.
  - rd_ptr_i increments (wraps); count_i decrements.
  - Latency from GNT sample to out_valid: 1 cycle.
  - A GNT held high for k cycles pops up to k entries (one per cycle) while the FIFO is non-empty.
- Over-grant: the arbiter's registered GNT lags REQ by one cycle, so a grant to an empty FIFO is normal. It is silently ignored: no pop, out_valid=0 next cycle, no error.
- GNT==0: no pop, out_valid=0 next cycle.
- Multi-hot GNT: no pop anywhere, out_valid=0 next cycle, err_gnt set. err_gnt stays set until reset.
- Simultaneous push and pop on the same FIFO:
  - Both occur; count unchanged.
  - On a full FIFO, push is refused because in_ready was 0 that cycle, even though a pop frees a slot.
  - On an empty FIFO, pop is not possible; the push lands and REQ rises next cycle.
- Counts: DEPTH is representable in CNT_W bits; count never exceeds DEPTH or underflows.
- No output backpressure: the consumer must accept every out_valid cycle.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> REQ=0000, in_ready=1111, out_valid=0, err_gnt=0, drop_cnt=0.
- Single push/pop: push 8'hA5 on requester 1, then GNT=0010 one cycle -> REQ=0010 one cycle after push; out_valid=1, out_data=A5, out_src=1 one cycle after GNT; REQ=0000 afterwards.
- Fill and overflow: push 5 words 01..05 on requester 3 back-to-back (DEPTH=4) -> in_ready[3]=0 after 4th push, drop_cnt=1. Then GNT=1000 for 5 cycles -> out_data 01,02,03,04 on consecutive cycles; 5th (over-grant) gives out_valid=0 and err_gnt stays 0.
- Rotating grants: preload FIFO0=10, FIFO1=20, FIFO2=30, FIFO3=40; GNT=0001,0010,0100,1000 on consecutive cycles -> out_data 10,20,30,40 with out_src 0,1,2,3 on consecutive cycles; REQ ends 0000.
- Pointer wrap with concurrent push/pop: on requester 2, stream 10 words while GNT=0100 continuously after the first entry -> all 10 words emerge in order, count never exceeds 2, no drops.
- Illegal grant and mid-operation reset: with FIFO0 and FIFO1 non-empty, drive GNT=0011 -> no pop, out_valid=0, err_gnt=1 sticky. Then assert rst=0 for one cycle during a push -> REQ=0000, err_gnt=0, pushed word discarded.
